sequence_loader: RTL and testbench

Upstream stage of the sequence processor. Accepts a stream of K bytes over a valid/ready handshake and writes each into shared byte memory as a value/credibility word pair (value at base + 2·i, credibility byte at base + 2·i + 1). Optionally, it then launches the sequence processor over the same region, waits for it to finish, and reports completion.

---
 rtl/seq_pkg.sv | 23 ++
 rtl/seq_word_addr.sv | 18 +
 rtl/sequence_loader.sv | 169 ++++++++++++++++
 tb/tb_sequence_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by sequence_loader and the sequence processor.
//   ADDR_W       - memory byte address width
//   LEN_W        - sequence length (word count) width
//   CRED_DEFAULT - default credibility byte
//   seq_state_t  - 4-bit state encoding
package seq_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 10;

    localparam logic [7:0] CRED_DEFAULT = 8'd0;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_BYTE  = 4'd1,
        ST_WR_VALUE   = 4'd2,
        ST_WR_CRED    = 4'd3,
        ST_PROC_START = 4'd4,
        ST_PROC_WAIT  = 4'd5,
        ST_DONE       = 4'd6
    } seq_state_t;

endpackage

// File: rtl/seq_word_addr.sv
// seq_word_addr: byte address of one half of a value/credibility word pair.
//   base_i   - region base byte address
//   idx_i    - word index
//   offset_i - 0 selects the value byte, 1 selects the credibility byte
//   addr_o   - base_i + 2*idx_i + offset_i, modulo 2^ADDR_W
module seq_word_addr
    import seq_pkg::*;
(
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  idx_i,
    input  logic              offset_i,
    output logic [ADDR_W-1:0] addr_o
);

    // 2*idx + offset is just idx with offset appended as the LSB.
    assign addr_o = base_i + {{(ADDR_W-LEN_W-1){1'b0}}, idx_i, offset_i};

endmodule

// File: rtl/sequence_loader.sv
// sequence_loader: accepts K stream bytes over valid/ready and writes each as a
// value/credibility pair into byte memory (value at base+2i, credibility at
// base+2i+1). With SEQ_LOADER_AUTO_START_EN defined it then launches the
// sequence processor over the region and waits for its done level.
//   I_CLOCK/I_RESET       - clock, asynchronous active-high reset
//   I_START, I_ADD, I_K   - start level, base address, word count
//   I_S_DATA/I_S_VALID    - input stream; O_S_READY accepts
//   O_MEMORY_*            - memory port (ownership, address, write data/strobe)
//   O_PROC_START/I_PROC_DONE - processor handshake (tied off when macro undefined)
//   O_BUSY, O_WORD_COUNT, O_DONE - status
// Every output is registered from the next-state value.
module sequence_loader
    import seq_pkg::*;
#(
    parameter logic [7:0] CRED_INIT = CRED_DEFAULT
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET,
    input  logic              I_START,
    input  logic [ADDR_W-1:0] I_ADD,
    input  logic [LEN_W-1:0]  I_K,
    input  logic [7:0]        I_S_DATA,
    input  logic              I_S_VALID,
    output logic              O_S_READY,
    output logic [ADDR_W-1:0] O_MEMORY_ADDRESS,
    output logic              O_MEMORY_ENABLE,
    output logic [7:0]        O_MEMORY_WRITE_DATA,
    output logic              O_MEMORY_WRITE_ENABLE,
    output logic              O_PROC_START,
    input  logic              I_PROC_DONE,
    output logic              O_BUSY,
    output logic [LEN_W-1:0]  O_WORD_COUNT,
    output logic              O_DONE
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] word_addr;

    seq_word_addr u_word_addr (
        .base_i   (base_q),
        .idx_i    (idx_q),
        .offset_i (state_q == ST_WR_VALUE),
        .addr_o   (word_addr)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (I_START) begin
                    base_d = I_ADD;
                    k_d    = I_K;
                    idx_d  = '0;
                    if (I_K != '0) begin
                        state_d = ST_WAIT_BYTE;
                    end else begin
`ifdef SEQ_LOADER_AUTO_START_EN
                        state_d = ST_PROC_START;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_WAIT_BYTE: begin
                if (I_S_VALID && O_S_READY) begin
                    state_d = ST_WR_VALUE;
                end
            end
            ST_WR_VALUE: begin
                state_d = ST_WR_CRED;
            end
            ST_WR_CRED: begin
                idx_d = LEN_W'(idx_q + 1'b1);
                if (idx_d == k_q) begin
`ifdef SEQ_LOADER_AUTO_START_EN
                    state_d = ST_PROC_START;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_WAIT_BYTE;
                end
            end
`ifdef SEQ_LOADER_AUTO_START_EN
            ST_PROC_START: begin
                state_d = ST_PROC_WAIT;
            end
            ST_PROC_WAIT: begin
                // Done is only looked at here, so the start level has already
                // been high for the whole PROC_START cycle.
                if (I_PROC_DONE) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (!I_START) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q               <= ST_IDLE;
            base_q                <= '0;
            k_q                   <= '0;
            idx_q                 <= '0;
            O_S_READY             <= 1'b0;
            O_MEMORY_ADDRESS      <= '0;
            O_MEMORY_ENABLE       <= 1'b0;
            O_MEMORY_WRITE_DATA   <= '0;
            O_MEMORY_WRITE_ENABLE <= 1'b0;
            O_BUSY                <= 1'b0;
            O_DONE                <= 1'b0;
        end else begin
            state_q               <= state_d;
            base_q                <= base_d;
            k_q                   <= k_d;
            idx_q                 <= idx_d;
            O_S_READY             <= (state_d == ST_WAIT_BYTE);
            O_MEMORY_ENABLE       <= (state_d inside {ST_WAIT_BYTE, ST_WR_VALUE, ST_WR_CRED});
            O_MEMORY_WRITE_ENABLE <= (state_d inside {ST_WR_VALUE, ST_WR_CRED});
            O_BUSY                <= (state_d != ST_IDLE);
            O_DONE                <= (state_d == ST_DONE);
            // The write-data register doubles as the captured stream byte.
            if (state_d == ST_WR_VALUE) begin
                O_MEMORY_WRITE_DATA <= I_S_DATA;
                O_MEMORY_ADDRESS    <= word_addr;
            end else if (state_d == ST_WR_CRED) begin
                O_MEMORY_WRITE_DATA <= CRED_INIT;
                O_MEMORY_ADDRESS    <= word_addr;
            end
        end
    end

    assign O_WORD_COUNT = idx_q;

`ifdef SEQ_LOADER_AUTO_START_EN
    logic proc_start_q;

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            proc_start_q <= 1'b0;
        end else begin
            proc_start_q <= (state_d inside {ST_PROC_START, ST_PROC_WAIT});
        end
    end

    assign O_PROC_START = proc_start_q;
`else
    logic unused_proc_done;

    assign unused_proc_done = I_PROC_DONE;
    assign O_PROC_START     = 1'b0;
`endif

endmodule

// File: tb/tb_sequence_loader.sv
module tb_sequence_loader;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET = 1'b1;
    logic        I_START = 1'b0;
    logic [15:0] I_ADD = '0;
    logic [9:0]  I_K = '0;
    logic [7:0]  I_S_DATA = '0;
    logic        I_S_VALID = 1'b0;
    logic        O_S_READY;
    logic [15:0] O_MEMORY_ADDRESS;
    logic        O_MEMORY_ENABLE;
    logic [7:0]  O_MEMORY_WRITE_DATA;
    logic        O_MEMORY_WRITE_ENABLE;
    logic        O_PROC_START;
    logic        I_PROC_DONE = 1'b0;
    logic        O_BUSY;
    logic [9:0]  O_WORD_COUNT;
    logic        O_DONE;

    localparam logic [7:0] CRED = 8'h00;

    sequence_loader #(.CRED_INIT(CRED)) dut (
        .I_CLOCK               (I_CLOCK),
        .I_RESET               (I_RESET),
        .I_START               (I_START),
        .I_ADD                 (I_ADD),
        .I_K                   (I_K),
        .I_S_DATA              (I_S_DATA),
        .I_S_VALID             (I_S_VALID),
        .O_S_READY             (O_S_READY),
        .O_MEMORY_ADDRESS      (O_MEMORY_ADDRESS),
        .O_MEMORY_ENABLE       (O_MEMORY_ENABLE),
        .O_MEMORY_WRITE_DATA   (O_MEMORY_WRITE_DATA),
        .O_MEMORY_WRITE_ENABLE (O_MEMORY_WRITE_ENABLE),
        .O_PROC_START          (O_PROC_START),
        .I_PROC_DONE           (I_PROC_DONE),
        .O_BUSY                (O_BUSY),
        .O_WORD_COUNT          (O_WORD_COUNT),
        .O_DONE                (O_DONE)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] stim[$];
    int         checks = 0;
    int         errors = 0;
    int         ready_cnt = 0;
    bit         proc_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, O_S_READY, 0);
        check({tag, "_addr"}, O_MEMORY_ADDRESS, 0);
        check({tag, "_mem_en"}, O_MEMORY_ENABLE, 0);
        check({tag, "_wdata"}, O_MEMORY_WRITE_DATA, 0);
        check({tag, "_we"}, O_MEMORY_WRITE_ENABLE, 0);
        check({tag, "_proc_start"}, O_PROC_START, 0);
        check({tag, "_busy"}, O_BUSY, 0);
        check({tag, "_count"}, O_WORD_COUNT, 0);
        check({tag, "_done"}, O_DONE, 0);
    endtask

    // Processor model: done level rises 20 cycles after the start level, and
    // follows the start level back down. Updates just after the rising edge.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge I_CLOCK);
            #1;
`ifdef SEQ_LOADER_AUTO_START_EN
            if (I_RESET || !O_PROC_START) begin
                cnt = 0;
                I_PROC_DONE = 1'b0;
            end else begin
                cnt++;
                if (cnt >= 20) I_PROC_DONE = 1'b1;
            end
`else
            I_PROC_DONE = 1'b0;
`endif
        end
    end

    // Monitor: pops the scoreboard on every write strobe and watches the
    // processor handshake.
    initial begin
        wr_t  e;
        logic prev_ps, prev_pd, prev_rst;
        prev_ps = 0; prev_pd = 0; prev_rst = 1;
        forever begin
            @(negedge I_CLOCK);
            if (!I_RESET) begin
                if (O_MEMORY_WRITE_ENABLE) begin
                    check("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("wr_addr", O_MEMORY_ADDRESS, e.a);
                        check("wr_data", O_MEMORY_WRITE_DATA, e.d);
                        check("wr_mem_en", O_MEMORY_ENABLE, 1);
                    end
                end
                if (O_S_READY) ready_cnt++;
`ifdef SEQ_LOADER_AUTO_START_EN
                if (O_PROC_START) begin
                    proc_seen = 1;
                    check("proc_mem_en_low", O_MEMORY_ENABLE, 0);
                end
                if (prev_ps && !prev_rst) begin
                    if (prev_pd) begin
                        check("proc_start_fall", O_PROC_START, 0);
                        check("done_after_proc", O_DONE, 1);
                    end else begin
                        check("proc_start_hold", O_PROC_START, 1);
                        check("done_before_proc", O_DONE, 0);
                    end
                end
`else
                if (O_DONE) check("proc_start_tied", O_PROC_START, 0);
`endif
            end
            prev_ps  = O_PROC_START;
            prev_pd  = I_PROC_DONE;
            prev_rst = I_RESET;
        end
    end

    task automatic push_expected(input logic [15:0] base);
        for (int unsigned i = 0; i < stim.size(); i++) begin
            sb.push_back('{a: base + 16'(2 * i), d: stim[i]});
            sb.push_back('{a: base + 16'(2 * i + 1), d: CRED});
        end
    endtask

    task automatic run_load(input logic [15:0] base, input logic [9:0] k, input bit rnd,
                            output int done_cycles);
        int n, budget;
        bit v;
        push_expected(base);
        proc_seen = 0;
        @(negedge I_CLOCK);
        I_ADD = base;
        I_K = k;
        I_START = 1'b1;
        n = 0;
        budget = 0;
        while (n < int'(k) && budget < 500) begin
            @(negedge I_CLOCK);
            budget++;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            I_S_VALID = v;
            I_S_DATA = v ? stim[n] : ~stim[n];
            if (v && O_S_READY) n++;
        end
        check("accepted_bytes", n, k);
        budget = 0;
        while (!O_DONE && budget < 200) begin
            @(negedge I_CLOCK);
            I_S_VALID = 1'b0;
            budget++;
        end
        done_cycles = budget;
        I_S_VALID = 1'b0;
        check("done_seen", O_DONE, 1);
        check("word_count", O_WORD_COUNT, k);
        check("busy_in_done", O_BUSY, 1);
        check("mem_en_in_done", O_MEMORY_ENABLE, 0);
        check("sb_drained", sb.size(), 0);
`ifdef SEQ_LOADER_AUTO_START_EN
        check("proc_launched", proc_seen, 1);
`endif
        I_START = 1'b0;
        @(negedge I_CLOCK);
        @(negedge I_CLOCK);
        check("idle_busy", O_BUSY, 0);
        check("idle_done", O_DONE, 0);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        I_RESET = 1'b1;
        #1;
        check_outputs_zero(tag);
        sb.delete();
        @(negedge I_CLOCK);
        I_START = 1'b0;
        I_S_VALID = 1'b0;
        #2;
        I_RESET = 1'b0;
    endtask

    initial begin
        int dc, budget;
        #1;
        check_outputs_zero("reset");
        #20;
        @(negedge I_CLOCK);
        I_RESET = 1'b0;
        @(negedge I_CLOCK);
        check_outputs_zero("post_reset");

        // Basic load, continuous valid; ready must be high once per byte.
        stim = '{8'h11, 8'h00, 8'h22};
        ready_cnt = 0;
        run_load(16'h0100, 10'd3, 1'b0, dc);
        check("ready_cycles", ready_cnt, 3);

        // Same sequence, randomly toggling valid.
        stim = '{8'h11, 8'h00, 8'h22};
        run_load(16'h0100, 10'd3, 1'b1, dc);

        // Longer run with random data and valid.
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
        run_load(16'h1230, 10'd8, 1'b1, dc);

        // Address wrap past 0xFFFF.
        stim = '{8'hA1, 8'hB2};
        run_load(16'hFFFE, 10'd2, 1'b0, dc);

        // Zero-length sequence: no writes.
        stim.delete();
        run_load(16'h0500, 10'd0, 1'b0, dc);
`ifndef SEQ_LOADER_AUTO_START_EN
        check("k0_done_latency_ok", dc <= 2, 1);
`endif

        // Reset during a credibility write, then a clean run from idx 0.
        stim = '{8'hAA, 8'hBB};
        push_expected(16'h0200);
        @(negedge I_CLOCK);
        I_ADD = 16'h0200;
        I_K = 10'd2;
        I_START = 1'b1;
        I_S_VALID = 1'b1;
        I_S_DATA = 8'hAA;
        budget = 0;
        while (!(O_MEMORY_WRITE_ENABLE && O_MEMORY_ADDRESS[0]) && budget < 50) begin
            @(negedge I_CLOCK);
            budget++;
        end
        check("reached_wr_cred", O_MEMORY_WRITE_ENABLE && O_MEMORY_ADDRESS[0], 1);
        pulse_reset("rst_wr_cred");
        stim = '{8'h5A, 8'hA5};
        run_load(16'h0300, 10'd2, 1'b0, dc);

`ifdef SEQ_LOADER_AUTO_START_EN
        // Reset while waiting on the processor.
        stim = '{8'h77};
        push_expected(16'h0400);
        @(negedge I_CLOCK);
        I_ADD = 16'h0400;
        I_K = 10'd1;
        I_START = 1'b1;
        I_S_VALID = 1'b1;
        I_S_DATA = 8'h77;
        budget = 0;
        while (!O_PROC_START && budget < 50) begin
            @(negedge I_CLOCK);
            I_S_VALID = 1'b0;
            budget++;
        end
        check("reached_proc_wait", O_PROC_START, 1);
        repeat (3) @(negedge I_CLOCK);
        pulse_reset("rst_proc_wait");
        stim = '{8'h3C};
        run_load(16'h0400, 10'd1, 1'b0, dc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
